// File: rtl/pipe_ctrl_pkg.sv
// Shared types and control presets for the pipeline hazard sequencer.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        MD_WAIT  = 2'd2,
        FAULT    = 2'd3
    } state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic id_ex_write;
        logic ex_mem_write;
        logic if_id_flush;
        logic id_ex_flush;
        logic ex_mem_flush;
        logic mem_wb_flush;
    } ctrl_t;

    localparam ctrl_t CTRL_DEFAULT   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam ctrl_t CTRL_MEM_STALL = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    localparam ctrl_t CTRL_MD_STALL  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    localparam ctrl_t CTRL_LOAD_USE  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    localparam ctrl_t CTRL_BRANCH    = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    localparam ctrl_t CTRL_FAULT     = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

endpackage

// File: rtl/load_use_detect.sv
// Flags a load in EX whose destination is a source of the instruction in ID.
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic       ex_mem_read,
    input  logic       ex_reg_write,
    input  logic [4:0] ex_write_register,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    output logic       hazard
);

    assign hazard = ex_mem_read && ex_reg_write && (ex_write_register != REG_ZERO) &&
                    ((ex_write_register == id_rs) || (ex_write_register == id_rt));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline: load-use, branch, data-memory wait
// with timeout fault, fixed-latency mul/div, and a saturating stall-cycle counter.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MD_CYCLES   = 4,
    parameter int MEM_TIMEOUT = 255,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [4:0]             id_rs,
    input  logic [4:0]             id_rt,
    input  logic                   ex_mem_read,
    input  logic                   ex_reg_write,
    input  logic [4:0]             ex_write_register,
    input  logic                   id_branch_taken,
    input  logic                   ex_muldiv,
    input  logic                   mem_dmem_req,
    input  logic                   dmem_ready,
    output logic                   pc_write,
    output logic                   if_id_write,
    output logic                   id_ex_write,
    output logic                   ex_mem_write,
    output logic                   if_id_flush,
    output logic                   id_ex_flush,
    output logic                   ex_mem_flush,
    output logic                   mem_wb_flush,
    output logic                   md_busy,
    output logic                   mem_fault,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    localparam logic [3:0] MD_INIT   = 4'(MD_CYCLES - 1);
    localparam logic [7:0] TMO_LIMIT = 8'(MEM_TIMEOUT);

    state_e     state;
    state_e     state_nxt;
    ctrl_t      ctrl;
    logic [3:0] cnt;
    logic [7:0] tmo;
    logic       md_done;
    logic       hazard;
    logic       mem_stall;
    logic       md_start;

    load_use_detect u_load_use_detect (
        .ex_mem_read       (ex_mem_read),
        .ex_reg_write      (ex_reg_write),
        .ex_write_register (ex_write_register),
        .id_rs             (id_rs),
        .id_rt             (id_rt),
        .hazard            (hazard)
    );

    assign mem_stall = mem_dmem_req && !dmem_ready;
    // md_done masks the mul/div that is still in EX on its release cycle
    assign md_start  = ex_muldiv && !md_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= RUN;
            cnt          <= '0;
            tmo          <= '0;
            md_done      <= 1'b0;
            stall_cycles <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                RUN: begin
                    md_done <= 1'b0;
                    if (mem_stall)     tmo <= 8'd1;
                    else if (md_start) cnt <= MD_INIT;
                end
                MEM_WAIT: if (!dmem_ready) tmo <= tmo + 8'd1;
                MD_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) md_done <= 1'b1;
                end
                default: ;
            endcase
            if (!ctrl.pc_write && (stall_cycles != {STALL_CNT_W{1'b1}}))
                stall_cycles <= stall_cycles + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN: begin
                if (mem_stall)     state_nxt = MEM_WAIT;
                else if (md_start) state_nxt = MD_WAIT;
            end
            MEM_WAIT: begin
                if (dmem_ready)            state_nxt = RUN;
                else if (tmo == TMO_LIMIT) state_nxt = FAULT;
            end
            MD_WAIT:  if (cnt == 4'd1) state_nxt = RUN;
            FAULT:    state_nxt = FAULT;
            default:  state_nxt = RUN;
        endcase
    end

    always_comb begin
        ctrl = CTRL_DEFAULT;
        if (!reset) begin
            case (state)
                RUN: begin
                    if (mem_stall)            ctrl = CTRL_MEM_STALL;
                    else if (md_start)        ctrl = CTRL_MD_STALL;
                    else if (hazard)          ctrl = CTRL_LOAD_USE;
                    else if (id_branch_taken) ctrl = CTRL_BRANCH;
                end
                MEM_WAIT: if (!dmem_ready) ctrl = CTRL_MEM_STALL;
                MD_WAIT:  ctrl = CTRL_MD_STALL;
                FAULT:    ctrl = CTRL_FAULT;
                default:  ctrl = CTRL_DEFAULT;
            endcase
        end
    end

    assign pc_write     = ctrl.pc_write;
    assign if_id_write  = ctrl.if_id_write;
    assign id_ex_write  = ctrl.id_ex_write;
    assign ex_mem_write = ctrl.ex_mem_write;
    assign if_id_flush  = ctrl.if_id_flush;
    assign id_ex_flush  = ctrl.id_ex_flush;
    assign ex_mem_flush = ctrl.ex_mem_flush;
    assign mem_wb_flush = ctrl.mem_wb_flush;
    assign md_busy      = !reset && (state == MD_WAIT);
    assign mem_fault    = !reset && (state == FAULT);

endmodule
